// File: rtl/sd_img_responder.sv
// rtl/sd_img_responder.sv - virtual SD sector target serving a save image from internal block RAM
//
// Purpose:
//   Answers the core's sector requests (sd_rd / sd_wr) from a 2^LBA_BITS-sector
//   image held in block RAM, 256 x 16-bit words per sector, and raises the mount
//   notification (img_mounted / img_readonly / img_size) for the backup-RAM logic.
//
// Ports:
//   clk_sys       in   1   system clock, rising edge
//   reset_n       in   1   asynchronous active-low reset
//   sd_lba        in  32   sector address, latched when a request is accepted
//   sd_rd         in   1   read request (image -> core), level
//   sd_wr         in   1   write request (core -> image), level
//   sd_ack        out  1   high for the whole sector transfer
//   sd_buff_addr  out  8   word index within the sector
//   sd_buff_dout  out 16   read data to the core
//   sd_buff_wr    out  1   strobe: sd_buff_dout valid for sd_buff_addr
//   sd_buff_din   in  16   write data, one cycle behind sd_buff_addr
//   mount_req     in   1   single-cycle mount pulse
//   mount_ro      in   1   read-only flag, sampled with mount_req
//   img_mounted   out  1   one-cycle pulse on completed mount
//   img_readonly  out  1   latched read-only flag
//   img_size      out 64   image size in bytes, 0 until first mount

module sd_img_responder #(
  parameter int LBA_BITS  = 4,
  parameter int ACK_DELAY = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [15:0] sd_buff_din,
  input  logic        mount_req,
  input  logic        mount_ro,
  output logic        img_mounted,
  output logic        img_readonly,
  output logic [63:0] img_size
);

  localparam int          AW        = LBA_BITS + 8;
  localparam int          WORDS     = 1 << AW;
  localparam logic [63:0] IMG_BYTES = 64'd512 << LBA_BITS;
  // Last DELAY count value; unused when ACK_DELAY is 0 because DELAY is skipped.
  localparam logic [3:0]  DLY_LAST  = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);

  typedef enum logic [2:0] {IDLE, DELAY, XFER_RD, XFER_WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [LBA_BITS-1:0] lba_q;
  logic                lba_oor;
  logic                dir_rd;
  logic [3:0]          dcnt;
  logic [8:0]          xcnt;      // word index in [8:1], phase in [0]
  logic                rd_hit;
  logic                mounted;
  logic                mnt_pend;
  logic                pend_ro;
  logic                accept;
  logic                in_xfer;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;
  logic [15:0]         ram_q;
  logic [15:0]         mem [0:WORDS-1];

  assign accept   = (state_q == IDLE) && mounted && (sd_rd || sd_wr);
  assign in_xfer  = (state_q == XFER_RD) || (state_q == XFER_WR);
  assign ram_addr = {lba_q, xcnt[8:1]};
  // Write on the odd phase, when the core's registered din reflects this word.
  assign ram_we   = (state_q == XFER_WR) && xcnt[0] && !lba_oor && !img_readonly;

  // sd_ack and sd_buff_addr decode straight from state so reset drops them at once.
  assign sd_ack       = in_xfer;
  assign sd_buff_addr = in_xfer ? xcnt[8:1] : 8'd0;
  assign sd_buff_dout = rd_hit ? ram_q : 16'h0000;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ACK_DELAY == 0) state_d = sd_rd ? XFER_RD : XFER_WR;
          else                state_d = DELAY;
        end
      end
      DELAY: begin
        if (dcnt == DLY_LAST) state_d = dir_rd ? XFER_RD : XFER_WR;
      end
      XFER_RD, XFER_WR: begin
        if (xcnt == 9'd511) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lba_q        <= '0;
      lba_oor      <= 1'b0;
      dir_rd       <= 1'b0;
      dcnt         <= 4'd0;
      xcnt         <= 9'd0;
      sd_buff_wr   <= 1'b0;
      rd_hit       <= 1'b0;
      mounted      <= 1'b0;
      mnt_pend     <= 1'b0;
      pend_ro      <= 1'b0;
      img_mounted  <= 1'b0;
      img_readonly <= 1'b0;
      img_size     <= 64'd0;
    end else begin
      dcnt       <= (state_q == DELAY) ? dcnt + 4'd1 : 4'd0;
      xcnt       <= in_xfer ? xcnt + 9'd1 : 9'd0;
      // Read issued on the even phase; strobe and data appear one cycle later.
      sd_buff_wr <= (state_q == XFER_RD) && !xcnt[0];
      rd_hit     <= (state_q == XFER_RD) && !xcnt[0] && !lba_oor;

      if (accept) begin
        lba_q   <= sd_lba[LBA_BITS-1:0];
        lba_oor <= |sd_lba[31:LBA_BITS];
        dir_rd  <= sd_rd;
      end

      // Mounts only take effect in IDLE so img_readonly never changes mid-sector;
      // a request arriving while busy is parked and the latest mount_ro wins.
      img_mounted <= 1'b0;
      if ((state_q == IDLE) && (mount_req || mnt_pend)) begin
        img_mounted  <= 1'b1;
        img_readonly <= mount_req ? mount_ro : pend_ro;
        img_size     <= IMG_BYTES;
        mounted      <= 1'b1;
        mnt_pend     <= 1'b0;
      end else if (mount_req) begin
        mnt_pend <= 1'b1;
        pend_ro  <= mount_ro;
      end
    end
  end

  // Image storage: deliberately not reset so contents survive a reset.
  always_ff @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= sd_buff_din;
    ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_sd_img_responder.sv
// tb/tb_sd_img_responder.sv - self-checking bench for sd_img_responder
`timescale 1ns/1ps

module tb_sd_img_responder;

  localparam int LB = 4;
  localparam int AD = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sd_lba = 32'd0;
  logic        sd_rd = 1'b0;
  logic        sd_wr = 1'b0;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din = 16'h0000;
  logic        mount_req = 1'b0;
  logic        mount_ro = 1'b0;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;

  always #5 clk_sys = ~clk_sys;

  sd_img_responder #(.LBA_BITS(LB), .ACK_DELAY(AD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mount_req(mount_req),
    .mount_ro(mount_ro), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size)
  );

  typedef struct packed {logic [7:0] a; logic [15:0] d;} word_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] model [0:4095];
  word_t       exp_q[$];
  word_t       obs_q[$];
  int          o_rise, o_fall, o_wrs, o_addr_bad, o_even, o_mnt;
  logic        o_ack_rst;

  // Stimulus: request a sector, act as the core side, record what the DUT did.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba, input logic [15:0] base,
                      input bit axor, input int abort_off, input int mount_off);
    logic [7:0] prev;
    int off;
    bit seen;
    prev = 8'd0; seen = 0; off = 0;
    o_rise = -1; o_fall = -1; o_wrs = 0; o_addr_bad = 0; o_even = 0; o_mnt = 0; o_ack_rst = 1'b1;
    obs_q.delete();
    @(negedge clk_sys);
    sd_rd = rd; sd_wr = wr; sd_lba = lba;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk_sys);
      sd_buff_din = base ^ (axor ? {8'h00, prev} : 16'h0000);
      prev = sd_buff_addr;
      mount_req = 1'b0;
      if (img_mounted) o_mnt++;
      if (!seen && sd_ack) begin
        seen = 1; o_rise = k; sd_rd = 1'b0; sd_wr = 1'b0;
      end
      if (seen) begin
        off = k - o_rise;
        if (!sd_ack) begin
          o_fall = off;
          return;
        end
        if (sd_buff_wr) begin
          obs_q.push_back({sd_buff_addr, sd_buff_dout});
          o_wrs++;
          if (!off[0]) o_even++;
        end
        if (!rd && sd_buff_addr != 8'(off / 2)) o_addr_bad++;
        if (off == mount_off) begin mount_req = 1'b1; mount_ro = 1'b0; end
        if (off == abort_off) begin
          reset_n = 1'b0;
          #1 o_ack_rst = sd_ack;
          return;
        end
      end
    end
    sd_rd = 1'b0; sd_wr = 1'b0;
  endtask

  task automatic push_exp(input int lba);
    for (int i = 0; i < 256; i++)
      exp_q.push_back({8'(i), (lba < (1 << LB)) ? model[lba * 256 + i] : 16'h0000});
  endtask

  task automatic do_mount(input bit ro);
    @(negedge clk_sys);
    mount_req = 1'b1; mount_ro = ro;
    @(negedge clk_sys);
    mount_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (4) @(negedge clk_sys);
    n_chk++;
    if ({sd_ack, sd_buff_wr, img_mounted, img_readonly, sd_buff_addr, sd_buff_dout} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b wr=%b mnt=%b ro=%b addr=%h dout=%h want all 0",
               sd_ack, sd_buff_wr, img_mounted, img_readonly, sd_buff_addr, sd_buff_dout);
    end
    n_chk++;
    if (img_size !== 64'd0) begin n_fail++; $display("FAIL reset_img_size got %0d want 0", img_size); end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_unmounted;
    int acks;
    acks = 0;
    sd_lba = 32'd0; sd_rd = 1'b1;
    repeat (50) begin @(negedge clk_sys); if (sd_ack) acks++; end
    sd_rd = 1'b0;
    n_chk++;
    if (acks != 0) begin n_fail++; $display("FAIL unmounted_ack got %0d ack cycles want 0", acks); end
    n_chk++;
    if (img_size !== 64'd0) begin n_fail++; $display("FAIL unmounted_size got %0d want 0", img_size); end
    @(negedge clk_sys);
  endtask

  task automatic test_mount;
    int pulses;
    do_mount(1'b0);
    pulses = img_mounted ? 1 : 0;
    repeat (4) begin @(negedge clk_sys); if (img_mounted) pulses++; end
    n_chk++;
    if (pulses != 1) begin n_fail++; $display("FAIL mount_pulses got %0d want 1", pulses); end
    n_chk++;
    if (img_size !== 64'd8192) begin n_fail++; $display("FAIL mount_size got %0d want 8192", img_size); end
    n_chk++;
    if (img_readonly !== 1'b0) begin n_fail++; $display("FAIL mount_ro got %b want 0", img_readonly); end
  endtask

  task automatic test_mount_read;
    word_t ow, ew;
    xfer(0, 1, 3, 16'h3000, 1, -1, -1);
    for (int i = 0; i < 256; i++) model[3 * 256 + i] = 16'h3000 + 16'(i);
    n_chk++;
    if (o_rise != AD + 1 || o_fall != 512 || o_wrs != 0 || o_addr_bad != 0) begin
      n_fail++;
      $display("FAIL wr3_timing got rise=%0d fall=%0d strobes=%0d addr_bad=%0d want 3 512 0 0",
               o_rise, o_fall, o_wrs, o_addr_bad);
    end
    push_exp(3);
    xfer(1, 0, 3, 16'h0000, 0, -1, -1);
    n_chk++;
    if (o_rise != AD + 1 || o_fall != 512 || o_even != 0) begin
      n_fail++;
      $display("FAIL rd3_timing got rise=%0d fall=%0d even_strobes=%0d want 3 512 0", o_rise, o_fall, o_even);
    end
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL rd3_count got %0d want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL rd3_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
  endtask

  task automatic test_write_readback;
    word_t ow, ew;
    xfer(0, 1, 5, 16'hFFFF, 1, -1, -1);
    for (int i = 0; i < 256; i++) model[5 * 256 + i] = 16'hFFFF - 16'(i);
    push_exp(5);
    xfer(1, 0, 5, 16'h0000, 0, -1, -1);
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL rd5_count got %0d want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL rd5_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
    do_mount(1'b1);
    n_chk++;
    if (img_readonly !== 1'b1) begin n_fail++; $display("FAIL ro_flag got %b want 1", img_readonly); end
    xfer(0, 1, 5, 16'h1234, 0, -1, -1);
    n_chk++;
    if (o_rise != AD + 1 || o_fall != 512 || o_wrs != 0) begin
      n_fail++;
      $display("FAIL ro_wr_timing got rise=%0d fall=%0d strobes=%0d want 3 512 0", o_rise, o_fall, o_wrs);
    end
    push_exp(5);
    xfer(1, 0, 5, 16'h0000, 0, -1, -1);
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL ro_rd_count got %0d want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL ro_rd_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
    do_mount(1'b0);
    n_chk++;
    if (img_readonly !== 1'b0) begin n_fail++; $display("FAIL rw_flag got %b want 0", img_readonly); end
  endtask

  task automatic test_back_to_back;
    word_t ow, ew;
    for (int s = 0; s < 16; s++) begin
      xfer(0, 1, 32'(s), {4'hA, 4'(s), 8'h00}, 1, -1, -1);
      for (int i = 0; i < 256; i++) model[s * 256 + i] = 16'hA000 + 16'(s * 256) + 16'(i);
      n_chk++;
      if (o_rise != AD + 1 || o_fall != 512) begin
        n_fail++;
        $display("FAIL save_timing sector=%0d got rise=%0d fall=%0d want 3 512", s, o_rise, o_fall);
      end
    end
    for (int s = 0; s < 16; s++) begin
      push_exp(s);
      xfer(1, 0, 32'(s), 16'h0000, 0, -1, -1);
      n_chk++;
      if (obs_q.size() != 256) begin n_fail++; $display("FAIL load_count sector=%0d got %0d want 256", s, obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        ow = obs_q.pop_front(); ew = exp_q.pop_front();
        n_chk++;
        if (ow !== ew) begin
          n_fail++;
          $display("FAIL load_word sector=%0d got %h:%h want %h:%h", s, ow.a, ow.d, ew.a, ew.d);
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_out_of_range;
    word_t ow, ew;
    push_exp(16);
    xfer(1, 0, 16, 16'h0000, 0, -1, -1);
    n_chk++;
    if (o_rise != AD + 1 || o_fall != 512 || obs_q.size() != 256) begin
      n_fail++;
      $display("FAIL oor_rd got rise=%0d fall=%0d strobes=%0d want 3 512 256", o_rise, o_fall, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL oor_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
    xfer(0, 1, 16, 16'hBEEF, 0, -1, -1);
    n_chk++;
    if (o_rise != AD + 1 || o_fall != 512) begin
      n_fail++;
      $display("FAIL oor_wr got rise=%0d fall=%0d want 3 512", o_rise, o_fall);
    end
    push_exp(0);
    xfer(1, 0, 0, 16'h0000, 0, -1, -1);
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL oor_alias_count got %0d want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL oor_alias_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
  endtask

  task automatic test_both_high;
    word_t ow, ew;
    push_exp(7);
    xfer(1, 1, 7, 16'h7777, 0, -1, -1);
    push_exp(7);
    xfer(1, 0, 7, 16'h0000, 0, -1, -1);
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL both_reread_count got %0d want 256", obs_q.size()); end
    // First pass's expectations were only for sequencing; compare the re-read against the tail.
    while (exp_q.size() > 256) void'(exp_q.pop_front());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL both_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
  endtask

  task automatic test_both_high_strobes;
    word_t ow, ew;
    push_exp(8);
    xfer(1, 1, 8, 16'h8888, 0, -1, -1);
    n_chk++;
    if (obs_q.size() != 256) begin n_fail++; $display("FAIL both_strobes got %0d want 256", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL both_rd_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
  endtask

  task automatic test_mount_busy;
    word_t ow, ew;
    push_exp(2);
    xfer(1, 0, 2, 16'h0000, 0, -1, 10);
    n_chk++;
    if (o_mnt != 0) begin n_fail++; $display("FAIL busy_mnt_during got %0d pulses want 0", o_mnt); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL busy_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
    @(negedge clk_sys);
    n_chk++;
    if (img_mounted !== 1'b0) begin n_fail++; $display("FAIL busy_mnt_idle got %b want 0", img_mounted); end
    @(negedge clk_sys);
    n_chk++;
    if (img_mounted !== 1'b1) begin n_fail++; $display("FAIL busy_mnt_pulse got %b want 1", img_mounted); end
    @(negedge clk_sys);
    n_chk++;
    if (img_mounted !== 1'b0) begin n_fail++; $display("FAIL busy_mnt_after got %b want 0", img_mounted); end
  endtask

  task automatic test_reset_mid;
    word_t ow, ew;
    xfer(0, 1, 9, 16'h5A00, 1, 100, -1);
    for (int i = 0; i < 50; i++) model[9 * 256 + i] = 16'h5A00 + 16'(i);
    n_chk++;
    if (o_ack_rst !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b want 0", o_ack_rst); end
    n_chk++;
    if ({sd_buff_wr, img_mounted, img_readonly, sd_buff_addr, sd_buff_dout} !== 27'd0 || img_size !== 64'd0) begin
      n_fail++;
      $display("FAIL abort_outputs got wr=%b mnt=%b ro=%b addr=%h dout=%h size=%0d want all 0",
               sd_buff_wr, img_mounted, img_readonly, sd_buff_addr, sd_buff_dout, img_size);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    n_chk++;
    if ({sd_ack, sd_buff_wr, sd_buff_addr} !== 10'd0) begin
      n_fail++;
      $display("FAIL release_idle got ack=%b wr=%b addr=%h want 0", sd_ack, sd_buff_wr, sd_buff_addr);
    end
    do_mount(1'b0);
    push_exp(9);
    xfer(1, 0, 9, 16'h0000, 0, -1, -1);
    n_chk++;
    if (o_rise != AD + 1 || obs_q.size() != 256) begin
      n_fail++;
      $display("FAIL abort_rd got rise=%0d strobes=%0d want 3 256", o_rise, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ow = obs_q.pop_front(); ew = exp_q.pop_front();
      n_chk++;
      if (ow !== ew) begin n_fail++; $display("FAIL abort_word got %h:%h want %h:%h", ow.a, ow.d, ew.a, ew.d); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_unmounted();
    test_mount();
    test_mount_read();
    test_write_readback();
    test_back_to_back();
    test_out_of_range();
    test_both_high();
    test_both_high_strobes();
    test_mount_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
